// File: rtl/toivoh_test_seconds.sv
// Seconds counter: a prescaler steps a decimal digit (mod 10) shown on a seven-segment display.
// The prescaler period comes from MAX_COUNT or from ui_in*1024, captured while reset is held.
module toivoh_test_seconds #(
  parameter int unsigned MAX_COUNT = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // MAX_COUNT = 2^24 truncates to 0, which still yields a 2^24 period via 24-bit wrap.
  localparam logic [23:0] MaxCount24 = 24'(MAX_COUNT);

  logic [23:0] r_cnt;
  logic [3:0]  r_digit;
  logic [23:0] r_compare;

  logic        w_last;
  logic [23:0] w_half;
  logic [6:0]  w_seg;
  logic        w_dp;
  logic        w_unused;

  assign w_unused = ^{ena, uio_in};

  // Period register has no async reset: it is loaded on every edge while reset is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_compare <= (ui_in != 8'd0) ? {6'b0, ui_in, 10'b0} : MaxCount24;
    end
  end

  assign w_last = (r_cnt == (r_compare - 24'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 24'd0;
      r_digit <= 4'd0;
    end else if (w_last) begin
      r_cnt   <= 24'd0;
      r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
    end else begin
      r_cnt   <= r_cnt + 24'd1;
    end
  end

  assign w_half = (r_compare == 24'd0) ? 24'h80_0000 : {1'b0, r_compare[23:1]};
  assign w_dp   = (r_cnt < w_half);

  always_comb begin
    w_seg = 7'h00;
    case (r_digit)
      4'd0:    w_seg = 7'h3F;
      4'd1:    w_seg = 7'h06;
      4'd2:    w_seg = 7'h5B;
      4'd3:    w_seg = 7'h4F;
      4'd4:    w_seg = 7'h66;
      4'd5:    w_seg = 7'h6D;
      4'd6:    w_seg = 7'h7D;
      4'd7:    w_seg = 7'h07;
      4'd8:    w_seg = 7'h7F;
      4'd9:    w_seg = 7'h6F;
      default: w_seg = 7'h00;
    endcase
  end

  assign uo_out  = {w_dp, w_seg};
  assign uio_out = {4'b0, r_digit};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_toivoh_test_seconds.sv
// Randomized bench for toivoh_test_seconds: an edge-count model predicts digit, prescaler and dp.
module tb_toivoh_test_seconds;

  localparam int unsigned MaxCount = 50;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  toivoh_test_seconds #(.MAX_COUNT(MaxCount)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Model: the display is a pure function of edges since release and the captured period.
  int m_period = 0;
  int m_edges  = 0;
  bit m_loaded = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_period = (ui_in != 8'd0) ? int'(ui_in) * 1024 : int'(MaxCount);
      m_edges  = 0;
      m_loaded = 1'b1;
    end else begin
      m_edges = m_edges + 1;
    end
  end

  always @(negedge rst_n) m_edges = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int         e_digit;
    int         e_cnt;
    logic [7:0] e_uo;
    if (rst_n && m_loaded) begin
      e_digit = (m_edges / m_period) % 10;
      e_cnt   = m_edges % m_period;
      e_uo    = {(e_cnt < m_period / 2), seg_tab[e_digit]};
      chk("cycle_uo_out", {24'd0, uo_out}, {24'd0, e_uo});
      chk("cycle_uio", {16'd0, uio_oe, uio_out}, {16'd0, 8'h0F, 4'h0, 4'(e_digit)});
    end else if (!rst_n) begin
      chk("reset_seg", {25'd0, uo_out[6:0]}, 32'h3F);
      chk("reset_uio", {16'd0, uio_oe, uio_out}, 32'h0F00);
    end
  end

  // Advance n rising edges, then settle 2 time units past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'd1;
    uio_in = 8'hA5;
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_seg", {25'd0, uo_out[6:0]}, 32'h3F);

    // Period 1024 from ui_in=1.
    step(10);
    chk("held_seg", {25'd0, uo_out[6:0]}, 32'h3F);
    chk("held_uio_out", {24'd0, uio_out}, 32'h00);
    chk("held_uio_oe", {24'd0, uio_oe}, 32'h0F);
    rst_n = 1'b1;
    step(1023);
    chk("edge1023_uo", {24'd0, uo_out}, 32'h3F);
    step(1);
    chk("edge1024_uo", {24'd0, uo_out}, 32'h86);
    chk("edge1024_uio", {24'd0, uio_out}, 32'h01);

    // Walk all ten digits and the 9 -> 0 wrap.
    for (int k = 2; k <= 10; k++) begin
      step(1024);
      chk("walk_seg", {25'd0, uo_out[6:0]}, {25'd0, seg_tab[k % 10]});
    end

    // ui_in changes while running are ignored.
    ui_in = 8'd2;
    step(1023);
    chk("ignore_ui_pre", {24'd0, uio_out}, 32'h00);
    step(1);
    chk("ignore_ui_step", {24'd0, uio_out}, 32'h01);

    // Reload period 2048.
    step(100);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    chk("reload_zero", {24'd0, uio_out}, 32'h00);
    step(2047);
    chk("p2048_pre", {24'd0, uio_out}, 32'h00);
    step(1);
    chk("p2048_step", {24'd0, uio_out}, 32'h01);

    // Asynchronous reset away from any clock edge.
    step(700);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_async_seg", {25'd0, uo_out[6:0]}, 32'h3F);
    chk("mid_async_uio", {28'd0, uio_out[3:0]}, 32'h0);

    // Default period (50) with ui_in=0.
    ui_in = 8'd0;
    step(2);
    rst_n = 1'b1;
    step(24);
    chk("dp_cnt24", {31'd0, uo_out[7]}, 32'h1);
    step(1);
    chk("dp_cnt25", {31'd0, uo_out[7]}, 32'h0);
    step(24);
    chk("dp_cnt49", {24'd0, uo_out}, 32'h3F);
    step(1);
    chk("p50_step", {24'd0, uo_out}, 32'h86);

    // Random periods, reset lengths, run lengths and ignored ui_in changes.
    for (int it = 0; it < 10; it++) begin
      ui_in = 8'($urandom_range(0, 2));
      rst_n = 1'b0;
      step($urandom_range(1, 3));
      rst_n = 1'b1;
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      step($urandom_range(60, 2500));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
